if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the control decoder.
- Owns the PC register and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register and presents its opcode/funct fields to the decoder.
- Applies PC redirects from jr/j/jal/taken-branch, pipeline stalls and IF/ID flushes; counts retired fetches.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, bubble word written into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  squash IF/ID contents (bubble).
- br_taken  input  1  branch/branchne resolved taken.
- br_target  input  32  branch target.
- jump  input  1  j/jal/jr redirect request.
- jumpr  input  1  with jump: use jr_target instead of j_target.
- j_target  input  32  j/jal target.
- jr_target  input  32  register target for jr.
- imem_addr  output  32  instruction-memory address (= pc).
- imem_rdata  input  32  instruction word, combinational read of imem_addr.
- pc  output  32  current fetch PC.
- ifid_instr  output  32  registered instruction.
- ifid_pc4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- opcode  output  6  ifid_instr[31:26], to decoder.
- funct  output  6  ifid_instr[5:0], to decoder.
- fetch_cnt  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (async, immediate):
  - pc = PC_RESET.
  - ifid_instr = NOP_WORD, ifid_pc4 = 0, ifid_valid = 0, fetch_cnt = 0.
  - opcode/funct follow ifid_instr, so both read 0.
- imem_addr = pc, combinational. Fetch latency is 1 cycle: the word at pc appears on ifid_instr after the next rising edge.
- redirect = jump | br_taken.
- Next-PC priority, highest first:
  1. jump & jumpr → jr_target.
  2. jump & ~jumpr → j_target.
  3. br_taken → br_target.
  4. stall → pc (hold).
  5. otherwise → pc + 4.
- Targets: bits [1:0] forced to 00. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- IF/ID update per edge, highest first:
  1. redirect or flush → instr = NOP_WORD, pc4 = 0, valid = 0.
  2. stall → hold all IF/ID fields.
  3. otherwise → instr = imem_rdata, pc4 = pc + 4, valid = 1.
- Redirect and stall in the same cycle: redirect wins. PC loads the target and IF/ID is bubbled; the stalled instruction is the wrong-path one.
- Flush without redirect:
  - With stall: PC holds, IF/ID is bubbled.
  - Without stall: PC advances to pc+4, IF/ID is bubbled.
- fetch_cnt increments by 1 on each edge where IF/ID loads with valid = 1 (case 3). It wraps at 2^32.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once. The first edge after deassertion fetches PC_RESET.
- No combinational path from redirect/stall inputs to any output except through registers. imem_addr depends only on the pc register.

Test Plan:
- Reset release, PC_RESET = 0, imem returns word = address | 32'h2000_0000, no control inputs for 3 edges:
  - pc = 0 → 4 → 8 → 12.
  - ifid_instr = 32'h2000_0000, 32'h2000_0004, 32'h2000_0008.
  - ifid_pc4 = 4, 8, 12; valid = 1; fetch_cnt = 3.
- Stall for 2 cycles at pc = 8: pc stays 8, IF/ID holds the word from 4, fetch_cnt unchanged. On release, the next edge loads the word from 8 and pc = 12.
- jump = 1, jumpr = 0, j_target = 32'h0000_0103, together with stall = 1:
  - pc = 32'h0000_0100.
  - ifid_instr = 0, valid = 0, opcode = 0.
  - Next edge fetches from 0x100.
- jump = 1, jumpr = 1 and br_taken = 1 together, jr_target = 0x40, br_target = 0x80: pc = 0x40 (jr priority), IF/ID bubbled.
- PC = 32'hFFFF_FFFC, no stall: pc wraps to 0, ifid_pc4 = 0, valid = 1.
- Assert rst mid-stall after 5 fetches: immediately pc = PC_RESET, fetch_cnt = 0, valid = 0. After release, normal fetch resumes from PC_RESET.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, registers the fetched word into IF/ID and counts accepted fetches.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic        jumpr,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_cnt;

  logic        w_redirect;
  logic        w_bubble;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_redirect = jump | br_taken;
  assign w_bubble   = w_redirect | flush;
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-PC select: jr, j, branch, stall-hold, sequential; targets word-aligned
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump && jumpr) begin
      w_next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      w_next_pc = {j_target[31:2], 2'b00};
    end else if (br_taken) begin
      w_next_pc = {br_target[31:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // IF/ID pipeline register: bubble on redirect/flush, hold on stall, else load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_WORD;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (w_bubble) begin
      r_instr <= NOP_WORD;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_instr <= imem_rdata;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
    end
  end

  // Count every edge on which IF/ID accepts a real instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_bubble && !stall) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ifid_instr = r_instr;
  assign ifid_pc4   = r_pc4;
  assign ifid_valid = r_valid;
  assign opcode     = r_instr[31:26];
  assign funct      = r_instr[5:0];
  assign fetch_cnt  = r_cnt;

endmodule
